// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative multiply/divide unit.
//   - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
//   - control FSM state encoding
//   - ITER: number of CALC iterations (one product/quotient bit per cycle)
//   - DIV0_LO: quotient returned for a zero divisor
package muldiv_pkg;

  localparam int ITER  = 32;
  localparam int CNT_W = $clog2(ITER);

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  // Bit 1 selects divide, bit 0 selects unsigned.
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/negate32.sv
// negate32: conditional two's-complement negate, built as bitwise inversion
// followed by an incrementer.
//   en  : 1 = output ~a + cin, 0 = pass a through unchanged
//   cin : increment input; 1 for a stand-alone negate, or the carry of the
//         lower half when two instances form a 64-bit negate
//   a   : 32-bit input
//   y   : 32-bit result
module negate32 (
  input  logic        en,
  input  logic        cin,
  input  logic [31:0] a,
  output logic [31:0] y
);

  logic [31:0] inv;
  logic [31:0] inc;

  assign inv = ~a;
  assign inc = inv + {31'd0, cin};
  assign y   = en ? inc : a;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit MULT/MULTU/DIV/DIVU into HI/LO.
//   clk, reset  : single clock, synchronous active-high reset
//   start, op   : request an operation (sampled in IDLE only); op per op_e
//   A, B        : rs operand / dividend, rt operand / divisor
//   busy        : high during CALC and FIX
//   done        : one-cycle pulse, hi/lo valid from this cycle
//   hi, lo      : product upper/lower, or remainder/quotient
//   div_by_zero : set with done for a zero divisor, held until next accept
//
// Operands are reduced to magnitudes at accept, a 32-cycle unsigned
// shift-add or restoring shift-subtract runs in CALC, and FIX applies the
// sign correction and writes HI/LO.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  import muldiv_pkg::*;

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_e            state_reg, state_next;
  logic [1:0]        op_reg, op_next;
  logic              sign_a_reg, sign_a_next;
  logic              sign_b_reg, sign_b_next;
  logic              dz_pend_reg, dz_pend_next;
  logic [31:0]       mag_a_reg, mag_a_next;   // multiplicand
  logic [31:0]       mag_b_reg, mag_b_next;   // divisor
  logic [63:0]       acc_reg, acc_next;       // {hi half, lo half} working register
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [31:0]       hi_reg, hi_next;
  logic [31:0]       lo_reg, lo_next;
  logic              done_reg, done_next;
  logic              dz_reg, dz_next;

  // ---------------------------------------------------------------------
  // Accept-time decode and operand magnitudes
  // ---------------------------------------------------------------------
  logic        in_signed;
  logic        in_div;
  logic        in_dz;
  logic [31:0] opnd_raw [2];
  logic [31:0] opnd_mag [2];

  assign in_signed   = ~op[0];
  assign in_div      = op[1];
  assign in_dz       = in_div && (B == '0);
  assign opnd_raw[0] = A;
  assign opnd_raw[1] = B;

  // Unsigned ops keep the raw bits; signed ops negate negative operands.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      negate32 u_neg (
        .en  (in_signed & opnd_raw[gi][31]),
        .cin (1'b1),
        .a   (opnd_raw[gi]),
        .y   (opnd_mag[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // CALC iteration
  // ---------------------------------------------------------------------
  // Multiply: add multiplicand into the upper half when the multiplier LSB
  // (acc lower half) is set, then shift {carry, acc} right by one.
  logic [32:0] mul_sum;
  logic [63:0] mul_acc;

  assign mul_sum = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, mag_a_reg} : 33'd0);
  assign mul_acc = {mul_sum, acc_reg[31:1]};

  // Divide: shift the dividend MSB into the partial remainder and try the
  // subtraction. The remainder stays below the divisor, so the shifted value
  // is below twice the divisor and bit 32 of the difference is a clean
  // borrow flag; quotient bits shift into the low half.
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic        rem_ge;
  logic [63:0] div_acc;

  assign rem_sh   = {acc_reg[63:32], acc_reg[31]};
  assign rem_diff = rem_sh - {1'b0, mag_b_reg};
  assign rem_ge   = ~rem_diff[32];
  assign div_acc  = {(rem_ge ? rem_diff[31:0] : rem_sh[31:0]), acc_reg[30:0], rem_ge};

  logic last_iter;
  assign last_iter = (cnt_reg == CNT_W'(ITER - 1));

  // ---------------------------------------------------------------------
  // FIX sign correction
  // ---------------------------------------------------------------------
  // Multiply negates the full 64-bit product as two chained halves.
  // Divide negates quotient and remainder independently (the remainder
  // follows the sign of A), so the upper instance gets its own increment.
  logic        fix_signed;
  logic        fix_div;
  logic        neg_lo_en;
  logic        neg_hi_en;
  logic        hi_cin;
  logic [31:0] fix_lo;
  logic [31:0] fix_hi;

  assign fix_signed = ~op_reg[0];
  assign fix_div    = op_reg[1];
  assign neg_lo_en  = fix_signed & (sign_a_reg ^ sign_b_reg);
  assign neg_hi_en  = fix_signed & (fix_div ? sign_a_reg : (sign_a_reg ^ sign_b_reg));
  // Carry out of the lower negate is set exactly when the lower half is zero.
  assign hi_cin     = fix_div ? 1'b1 : (acc_reg[31:0] == 32'd0);

  negate32 u_fix_lo (
    .en  (neg_lo_en),
    .cin (1'b1),
    .a   (acc_reg[31:0]),
    .y   (fix_lo)
  );

  negate32 u_fix_hi (
    .en  (neg_hi_en),
    .cin (hi_cin),
    .a   (acc_reg[63:32]),
    .y   (fix_hi)
  );

  // ---------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Control FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = in_dz ? ST_FIX : ST_CALC;
        end
      end
      ST_CALC: begin
        if (last_iter) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Control FSM: outputs
  always_comb begin
    busy = (state_reg != ST_IDLE);
  end

  // ---------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------
  always_comb begin
    op_next      = op_reg;
    sign_a_next  = sign_a_reg;
    sign_b_next  = sign_b_reg;
    dz_pend_next = dz_pend_reg;
    mag_a_next   = mag_a_reg;
    mag_b_next   = mag_b_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    done_next    = 1'b0;
    dz_next      = dz_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          op_next      = op;
          sign_a_next  = in_signed & A[31];
          sign_b_next  = in_signed & B[31];
          mag_a_next   = opnd_mag[0];
          mag_b_next   = opnd_mag[1];
          cnt_next     = '0;
          dz_next      = 1'b0;
          dz_pend_next = in_dz;
          // A zero divisor skips CALC: preload the final HI/LO values.
          if (in_dz) begin
            acc_next = {A, DIV0_LO};
          end else begin
            acc_next = {32'd0, (in_div ? opnd_mag[0] : opnd_mag[1])};
          end
        end
      end
      ST_CALC: begin
        cnt_next = cnt_reg + CNT_W'(1);
        acc_next = fix_div ? div_acc : mul_acc;
      end
      ST_FIX: begin
        hi_next   = dz_pend_reg ? acc_reg[63:32] : fix_hi;
        lo_next   = dz_pend_reg ? acc_reg[31:0]  : fix_lo;
        dz_next   = dz_pend_reg;
        done_next = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg      <= '0;
      sign_a_reg  <= 1'b0;
      sign_b_reg  <= 1'b0;
      dz_pend_reg <= 1'b0;
      mag_a_reg   <= '0;
      mag_b_reg   <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
      dz_reg      <= 1'b0;
    end else begin
      op_reg      <= op_next;
      sign_a_reg  <= sign_a_next;
      sign_b_reg  <= sign_b_next;
      dz_pend_reg <= dz_pend_next;
      mag_a_reg   <= mag_a_next;
      mag_b_reg   <= mag_b_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      done_reg    <= done_next;
      dz_reg      <= dz_next;
    end
  end

  assign done        = done_reg;
  assign hi          = hi_reg;
  assign lo          = lo_reg;
  assign div_by_zero = dz_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed HI/LO, latency, busy
// length, div_by_zero behaviour, ignored mid-run starts and mid-op reset.
module tb_muldiv_unit;

  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dz;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .A           (a_in),
    .B           (b_in),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE (called 1 ns after an edge) and wait for done.
  // inj=1 pulses junk start requests so they are sampled at E3 and E20.
  task automatic do_op(input string tag, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                       input logic exp_dz, input int exp_lat, input bit inj);
    int cycles;
    int busy_cnt;
    cycles   = 0;
    busy_cnt = 0;
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    tick();                       // E0: accept
    start = 1'b0;
    check({tag, ".dz_clr"}, 64'(dz), 64'd0);
    while (!done && cycles < 100) begin
      if (busy) busy_cnt++;
      start = inj && (cycles == 2 || cycles == 19);
      if (start) begin
        op   = OP_DIVU;
        a_in = 32'd9;
        b_in = 32'd0;
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    check({tag, ".lat"}, 64'(cycles), 64'(exp_lat));
    check({tag, ".busy_len"}, 64'(busy_cnt), 64'(exp_lat));
    check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
    check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    check({tag, ".dz"}, 64'(dz), 64'(exp_dz));
    $display("[TB] %s op=%0d A=%08h B=%08h -> hi=%08h lo=%08h dz=%0b lat=%0d",
             tag, o, a, b, hi, lo, dz, cycles);
  endtask

  initial begin
    int done_seen;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a_in  = '0;
    b_in  = '0;
    repeat (3) tick();
    reset = 1'b0;
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.hi", 64'(hi), 64'd0);
    check("rst.lo", 64'(lo), 64'd0);
    check("rst.dz", 64'(dz), 64'd0);
    $display("[TB] reset: busy=%0b done=%0b hi=%08h lo=%08h", busy, done, hi, lo);

    // Each call starts in the done cycle of the previous one (back-to-back).
    do_op("mult_neg2x3",  OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 33, 1'b0);
    do_op("multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 1'b0);
    do_op("div_m7_2",     OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 1'b0);
    do_op("divu_by0",     OP_DIVU,  32'd100,       32'd0,         32'd100,       32'hFFFF_FFFF, 1'b1, 1,  1'b0);
    do_op("multu_3x4",    OP_MULTU, 32'd3,         32'd4,         32'd0,         32'd12,        1'b0, 33, 1'b0);
    do_op("div_min_m1",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 33, 1'b0);
    do_op("mult_min_sq",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0, 33, 1'b0);
    do_op("divu_100_7",   OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 33, 1'b0);
    do_op("div_7_m2",     OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0, 33, 1'b0);
    do_op("mult_m3xm5",   OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0,         32'd15,        1'b0, 33, 1'b0);
    do_op("multu_5x7_ign", OP_MULTU, 32'd5,        32'd7,         32'd0,         32'd35,        1'b0, 33, 1'b1);

    // Reset at E10 of a running MULTU 5x7.
    tick();
    start = 1'b1;
    op    = OP_MULTU;
    a_in  = 32'd5;
    b_in  = 32'd7;
    tick();                       // E0
    start = 1'b0;
    check("midrst.busy_before", 64'(busy), 64'd1);
    repeat (9) tick();            // now just after E9
    reset = 1'b1;
    tick();                       // E10
    reset = 1'b0;
    check("midrst.hi", 64'(hi), 64'd0);
    check("midrst.lo", 64'(lo), 64'd0);
    check("midrst.busy", 64'(busy), 64'd0);
    check("midrst.done", 64'(done), 64'd0);
    done_seen = 0;
    repeat (40) begin
      if (done) done_seen++;
      tick();
    end
    check("midrst.no_done", 64'(done_seen), 64'd0);
    $display("[TB] midrst: hi=%08h lo=%08h busy=%0b done_pulses=%0d", hi, lo, busy, done_seen);

    do_op("multu_5x7_after_rst", OP_MULTU, 32'd5, 32'd7, 32'd0, 32'd35, 1'b0, 33, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath, executing MULT, MULTU, DIV and DIVU into dedicated HI/LO registers. It sits beside the combinational ALU operators and is the sequential partner they lack: operands are accepted with a start pulse, the result is produced after a fixed iteration count, and completion is signalled with a done pulse. The pipeline control stalls MFHI/MFLO while `busy` is high.

## Interface
- `WIDTH`, 32: operand width; the iteration count equals `WIDTH`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `start`, input, 1: request an operation; sampled only in IDLE.
- `op`, input, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `A`, input, 32: rs operand / dividend.
- `B`, input, 32: rt operand / divisor.
- `busy`, output, 1: high from the cycle after accept until done.
- `done`, output, 1: one-cycle pulse; HI/LO are valid from this cycle.
- `hi`, output, 32: MULT upper product / DIV remainder.
- `lo`, output, 32: MULT lower product / DIV quotient.
- `div_by_zero`, output, 1: set with `done` when a DIV/DIVU had B=0; held until the next accept.

## Operation
- States: IDLE, CALC, FIX. On reset: state IDLE; `busy`, `done`, and `div_by_zero` are 0; `hi` and `lo` are 0.
- IDLE with `start`=1: latch `op`, |A|, |B| and the sign bits. Magnitudes are taken only for signed ops; an unsigned op uses the raw bits. Clear the iteration counter and `div_by_zero`, then go to CALC.
- IDLE with a divide op and B=0: go directly to FIX with a zero-divisor flag set.
- CALC runs exactly 32 iterations, then goes to FIX.
  - Multiply: radix-2 shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle, with a 33-bit partial remainder.
- FIX, one cycle, then return to IDLE and pulse `done`.
  - Multiply: negate the 64-bit product if the signs differ (signed op only).
  - Divide: negate the quotient if sign(A)≠sign(B); the remainder takes the sign of A.
  - Write `hi`/`lo`.
- Divide by zero: `lo`=32'hFFFF_FFFF, `hi`=A unchanged, `div_by_zero`=1.
- DIV of 0x8000_0000 by 0xFFFF_FFFF: `lo`=0x8000_0000, `hi`=0. This is the natural wrap and needs no special case.
- `start` outside IDLE is ignored; there is no queueing.
- `hi`/`lo` hold their value except in the FIX cycle.

## Timing
- Accept edge E0: `start` sampled in IDLE.
- E1–E32: the 32 CALC iterations.
- E33: FIX. `done` is high and `hi`/`lo` hold the new values in the cycle after E33. Normal latency is 33 edges from accept.
- `busy` is high in the cycles after E0 through E33 (the CALC and FIX cycles). It is low in the cycle `done` is high.
- Divide by zero: FIX at E1, `done` after E1. Latency is 1 edge, and `busy` is high for exactly one cycle.
- Back-to-back: `start` asserted in the `done` cycle is accepted; state is IDLE.
- Reset mid-operation: abort at the reset edge; all outputs take their reset values; `done` is never pulsed for the aborted op.

## Structure
- Shared package `muldiv_pkg`:
  - op encodings (`OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`)
  - state encoding
  - `ITER`=32
  - `DIV0_LO`=32'hFFFF_FFFF
- One sub-module `negate32`: two's-complement negate with an enable, built from inverters plus an incrementer. It is instantiated for operand magnitudes and for the FIX-stage sign correction (64-bit as two chained instances).
- Control FSM and datapath registers live in `muldiv_unit`.

## Test plan
- MULT A=0xFFFF_FFFE (−2), B=0x0000_0003 -> `done` 33 edges after accept; `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFFA.
- MULTU A=0xFFFF_FFFF, B=0xFFFF_FFFF -> `hi`=0xFFFF_FFFE, `lo`=0x0000_0001; `busy` high for exactly 33 cycles.
- DIV A=0xFFFF_FFF9 (−7), B=2 -> `lo`=0xFFFF_FFFD (−3), `hi`=0xFFFF_FFFF (−1).
- DIVU A=100, B=0 -> `done` after 1 edge; `lo`=0xFFFF_FFFF, `hi`=100, `div_by_zero`=1. A following MULTU 3×4 clears the flag at accept and gives `lo`=12, `hi`=0.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> `lo`=0x8000_0000, `hi`=0. MULT 0x8000_0000 × 0x8000_0000 -> `hi`=0x4000_0000, `lo`=0.
- Start MULTU 5×7, assert `reset` at E10 -> `hi`=`lo`=0 and `busy`=0 after that edge, with no `done`. `start` pulses at E3 and E20 of a running op are ignored, and the result is unchanged.
